// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if: key-command handshake between a command source and the keypad emulator.
//   key_code  - key index to press (row*4 + column)
//   key_valid - command valid, driven by the source
//   key_ready - emulator queue not full
interface keypad_emulator_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  modport master (output key_code, key_valid, input key_ready);
  modport slave  (input key_code, key_valid, output key_ready);
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 matrix-keypad responder with a key-command FIFO and deterministic contact bounce.
//   clk, rst    - clock, asynchronous active-high reset
//   col         - active-low column strobes from the scanner
//   fila        - active-low row returns (4'hF with contact open)
//   kif         - key command handshake (key_code/key_valid in, key_ready out)
//   busy        - pressing or commands still queued
//   active_key  - key currently (or last) pressed
//   press_done  - one-cycle pulse when a press sequence completes
module keypad_emulator #(
  parameter int HOLD_CYCLES   = 1000,
  parameter int BOUNCE_CYCLES = 64,
  parameter int GAP_CYCLES    = 200,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        col,
  output logic [3:0]        fila,
  keypad_emulator_if.slave  kif,
  output logic              busy,
  output logic [3:0]        active_key,
  output logic              press_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam bit NB = BOUNCE_CYCLES == 0;
  localparam logic [15:0] HL = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] BL = 16'(BOUNCE_CYCLES - 1);
  localparam logic [15:0] GL = 16'(GAP_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;
  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic          contact_q, contact_d;
  logic          press_done_q, press_done_d;
  logic [3:0]    key_q, key_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    mem [FIFO_DEPTH];
  logic          push, pop, bounce_d;
  // Readiness comes only from the registered count, so a pop in the full cycle never frees a slot early.
  assign kif.key_ready = !count_q[AW];
  assign push       = kif.key_valid && kif.key_ready;
  assign pop        = state_q == IDLE && count_q != '0;
  assign busy       = state_q != IDLE || count_q != '0;
  assign active_key = key_q;
  assign press_done = press_done_q;
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q - 16'd1;
    press_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (pop) begin
          state_d = NB ? HOLD : BOUNCE_IN;
          cnt_d   = NB ? HL : BL;
        end
      end
      BOUNCE_IN: if (cnt_q == '0) begin
        state_d = HOLD;
        cnt_d   = HL;
      end
      HOLD: if (cnt_q == '0) begin
        state_d = NB ? GAP : BOUNCE_OUT;
        cnt_d   = NB ? GL : BL;
      end
      BOUNCE_OUT: if (cnt_q == '0) begin
        state_d = GAP;
        cnt_d   = GL;
      end
      GAP: if (cnt_q == '0) begin
        state_d      = IDLE;
        cnt_d        = '0;
        press_done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // The LFSR steps once per cycle spent bouncing; contact tracks the state being entered.
    lfsr_d    = (state_q == BOUNCE_IN || state_q == BOUNCE_OUT) ?
                {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
    bounce_d  = state_d == BOUNCE_IN || state_d == BOUNCE_OUT;
    contact_d = state_d == HOLD || (bounce_d && lfsr_d[0]);
    key_d     = pop ? mem[rd_q] : key_q;
    wr_d      = push ? wr_q + 1'b1 : wr_q;
    rd_d      = pop ? rd_q + 1'b1 : rd_q;
    count_d   = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end
  always_comb begin
    fila = 4'hF;
    fila[key_q[3:2]] = contact_q ? col[key_q[1:0]] : 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lfsr_q       <= 8'hA5;
      contact_q    <= 1'b0;
      press_done_q <= 1'b0;
      key_q        <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
      contact_q    <= contact_d;
      press_done_q <= press_done_d;
      key_q        <= key_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      count_q      <= count_d;
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_q] <= kif.key_code;
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed, table-driven checks of the keypad emulator (two parameter sets).
module tb_keypad_emulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] col_a = 4'h0, col_b = 4'h0;
  logic [3:0] fila_a, fila_b, act_a, act_b;
  logic busy_a, busy_b, done_a, done_b;
  int n_tests = 0, n_fail = 0;
  keypad_emulator_if ia();
  keypad_emulator_if ib();
  always #5 clk = ~clk;
  keypad_emulator #(.HOLD_CYCLES(20), .BOUNCE_CYCLES(0), .GAP_CYCLES(5), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .col(col_a), .fila(fila_a), .kif(ia),
    .busy(busy_a), .active_key(act_a), .press_done(done_a));
  keypad_emulator #(.HOLD_CYCLES(10), .BOUNCE_CYCLES(4), .GAP_CYCLES(3), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .col(col_b), .fila(fila_b), .kif(ib),
    .busy(busy_b), .active_key(act_b), .press_done(done_b));

  typedef struct {logic [3:0] key; logic [3:0] col; logic [3:0] fila;} vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lnext(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Returns at the falling edge just after the enqueue edge.
  task automatic enq_a(input logic [3:0] k);
    @(negedge clk);
    ia.key_code = k;
    ia.key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ia.key_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] pats [4];
    logic [7:0] l;
    logic c, rdy;
    int k, bad;
    int acc [7];
    int exp_acc [7];
    vecs[0] = '{key: 4'd6,  col: 4'b1011, fila: 4'b1101};
    vecs[1] = '{key: 4'd6,  col: 4'b1101, fila: 4'b1111};
    vecs[2] = '{key: 4'd15, col: 4'b0000, fila: 4'b0111};
    vecs[3] = '{key: 4'd12, col: 4'b1110, fila: 4'b0111};
    vecs[4] = '{key: 4'd12, col: 4'b0111, fila: 4'b1111};
    vecs[5] = '{key: 4'd0,  col: 4'b1110, fila: 4'b1110};
    vecs[6] = '{key: 4'd3,  col: 4'b0111, fila: 4'b1110};
    vecs[7] = '{key: 4'd9,  col: 4'b0000, fila: 4'b1011};
    pats[0] = 4'b1110; pats[1] = 4'b1101; pats[2] = 4'b1011; pats[3] = 4'b0111;
    exp_acc = '{0, 0, 1, 2, 3, 4, 24};
    ia.key_valid = 1'b0; ia.key_code = 4'h0;
    ib.key_valid = 1'b0; ib.key_code = 4'h0;
    // Reset state with every column driven.
    repeat (2) @(negedge clk);
    chk("rst_fila", fila_a, 4'hF);
    chk("rst_ready", ia.key_ready, 1'b1);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_active_key", act_a, 4'h0);
    chk("rst_press_done", done_a, 1'b0);
    chk("rst_fila_b", fila_b, 4'hF);
    rst = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (fila_a !== 4'hF || busy_a !== 1'b0) bad++;
    end
    chk("idle_fila_busy", bad, 0);
    col_a = 4'hF;
    col_b = 4'hF;
    // Single press of key 6 with a scanning column pattern.
    enq_a(4'd6);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      col_a = pats[i % 4];
      #1;
      chk($sformatf("scan_fila_%0d", i), fila_a,
          (i <= 20 && pats[i % 4] == 4'b1011) ? 4'b1101 : 4'hF);
      chk($sformatf("scan_done_%0d", i), done_a, i == 26);
      if (i == 1) chk("scan_active_key", act_a, 4'd6);
    end
    col_a = 4'hF;
    // Table of key/column combinations sampled mid-HOLD.
    for (int v = 0; v < 8; v++) begin
      enq_a(vecs[v].key);
      repeat (3) @(negedge clk);
      col_a = vecs[v].col;
      #1;
      chk($sformatf("vec%0d_fila", v), fila_a, vecs[v].fila);
      repeat (23) @(negedge clk);
      chk($sformatf("vec%0d_done", v), done_a, 1'b1);
      col_a = 4'hF;
    end
    // Bounce pattern from the reset seed on the bouncing instance.
    col_b = 4'b1110;
    @(negedge clk);
    ib.key_code = 4'd0;
    ib.key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ib.key_valid = 1'b0;
    l = 8'hA5;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i <= 4 || (i >= 15 && i <= 18)) begin
        c = l[0];
        l = lnext(l);
      end else c = (i >= 5 && i <= 14);
      chk($sformatf("bounce_fila_%0d", i), fila_b, c ? 4'b1110 : 4'hF);
      chk($sformatf("bounce_done_%0d", i), done_b, i == 22);
    end
    col_b = 4'hF;
    // Queue fill with keys 1..6 held back-to-back; press period 1+2*4+10+3 = 22.
    @(negedge clk);
    k = 1;
    ib.key_code = 4'd1;
    ib.key_valid = 1'b1;
    for (int t = 0; t <= 140; t++) begin
      rdy = ib.key_ready;
      @(posedge clk);
      @(negedge clk);
      if (ib.key_valid && rdy) begin
        acc[k] = t;
        k++;
        if (k > 6) ib.key_valid = 1'b0;
        else ib.key_code = 4'(k);
      end
      if (t == 4) chk("q_ready_full", ib.key_ready, 1'b0);
      if (t >= 1 && (t - 1) % 22 == 0 && (t - 1) / 22 < 6)
        chk($sformatf("q_active_%0d", t), act_b, 4'((t - 1) / 22 + 1));
      if (t >= 22 && t % 22 == 0 && t / 22 < 6)
        chk($sformatf("q_hold_%0d", t), act_b, 4'(t / 22));
    end
    chk("q_accepted_count", k, 7);
    for (int j = 1; j <= 6; j++) chk($sformatf("q_accept_cycle_%0d", j), acc[j], exp_acc[j]);
    chk("q_busy_end", busy_b, 1'b0);
    // Reset mid-HOLD on key 15 with a second key queued behind it.
    enq_a(4'd15);
    ia.key_code = 4'd5;
    ia.key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ia.key_valid = 1'b0;
    repeat (8) @(negedge clk);
    col_a = 4'b0000;
    #1;
    chk("k15_fila", fila_a, 4'b0111);
    chk("k15_busy", busy_a, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_fila", fila_a, 4'hF);
    chk("mid_rst_busy", busy_a, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_a !== 1'b0 || fila_a !== 4'hF || busy_a !== 1'b0 || act_a !== 4'h0) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
